// File: rtl/pwm_motor_ctrl.sv
// H-bridge DC motor driver: synchronised switches, boundary-aligned PWM
// duty, and dead-time on every reversal while running.
module pwm_motor_ctrl #(
  parameter int PERIOD  = 8,
  parameter int DUTY_LO = 4,
  parameter int DUTY_HI = 6,
  parameter int DEAD    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] switch,
  output logic [2:0] motor
);

  localparam int CW = $clog2(PERIOD);
  localparam int DW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(DEAD + 1);

  localparam logic [CW-1:0] CMAX = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DLO  = DW'(DUTY_LO);
  localparam logic [DW-1:0] DHI  = DW'(DUTY_HI);
  localparam logic [TW-1:0] DT   = TW'(DEAD);
  localparam logic [TW-1:0] DT1  = TW'(1);

  logic [2:0]    s1;
  logic [2:0]    s;
  logic [CW-1:0] cnt;
  logic [DW-1:0] duty_act;
  logic [TW-1:0] dt;
  logic          dir_act;
  logic          dir_q;
  logic          en;
  logic          spd;
  logic          dir;
  logic          pwm;

  assign en  = s[0];
  assign spd = s[1];
  assign dir = s[2];
  assign pwm = DW'(cnt) < duty_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= '0;
      s        <= '0;
      cnt      <= '0;
      duty_act <= '0;
      dt       <= '0;
      dir_act  <= 1'b0;
      dir_q    <= 1'b0;
      motor    <= '0;
    end else begin
      s1    <= switch;
      s     <= s1;
      dir_q <= dir;
      cnt   <= (cnt == CMAX) ? '0 : cnt + 1'b1;
      if (cnt == CMAX)
        duty_act <= en ? (spd ? DHI : DLO) : '0;
      if (!en) begin
        dt      <= '0;
        dir_act <= dir;
        motor   <= '0;
      end else if (dt != '0) begin
        // another toggle mid dead-time restarts the full gap
        if (dir != dir_q) begin
          dt    <= DT;
          motor <= '0;
        end else if (dt == DT1) begin
          dt      <= '0;
          dir_act <= dir;
          motor   <= {dir, ~dir, pwm};
        end else begin
          dt    <= dt - 1'b1;
          motor <= '0;
        end
      end else if (dir != dir_act) begin
        dt    <= DT;
        motor <= '0;
      end else begin
        motor <= {dir_act, ~dir_act, pwm};
      end
    end
  end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// Directed bench for pwm_motor_ctrl: reset, duty, reversal dead-time,
// disable and mid-operation reset, with hand-derived cycle timing.
module tb_pwm_motor_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] switch;
  logic [2:0] motor;

  int vectors;
  int errors;
  int ncyc;

  pwm_motor_ctrl #(
    .PERIOD(8), .DUTY_LO(4), .DUTY_HI(6), .DEAD(4)
  ) dut (
    .clk(clk), .rst(rst), .switch(switch), .motor(motor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic wait_phase0();
    for (int i = 0; i < 8 && (ncyc % 8) != 0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    switch = 3'b000;
    tick();
    tick();
    vectors++;
    if (motor !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=000", motor);
    end
    rst = 1'b0;
    ncyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      vectors++;
      if (motor !== 3'b000) begin
        errors++;
        $display("FAIL idle k=%0d got=%b exp=000", k, motor);
      end
    end
  endtask

  task automatic test_fwd_low();
    logic [2:0] e;
    int p;
    wait_phase0();
    switch = 3'b001;
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k - 1) % 8;
      if (k <= 2) e = 3'b000;
      else if (k <= 8) e = 3'b010;
      else e = {2'b01, p < 4};
      vectors++;
      if (motor !== e) begin
        errors++;
        $display("FAIL fwd_low k=%0d got=%b exp=%b", k, motor, e);
      end
    end
  endtask

  task automatic test_fwd_high();
    logic [2:0] e;
    int p;
    wait_phase0();
    switch = 3'b011;
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k - 1) % 8;
      if (k <= 8) e = {2'b01, p < 4};
      else e = {2'b01, p < 6};
      vectors++;
      if (motor !== e) begin
        errors++;
        $display("FAIL fwd_high k=%0d got=%b exp=%b", k, motor, e);
      end
    end
  endtask

  task automatic test_reverse();
    logic [2:0] e;
    int p;
    wait_phase0();
    switch = 3'b111;
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k - 1) % 8;
      if (k <= 2) e = {2'b01, p < 6};
      else if (k <= 6) e = 3'b000;
      else e = {2'b10, p < 6};
      vectors++;
      if (motor !== e || (motor[2] & motor[1])) begin
        errors++;
        $display("FAIL reverse k=%0d got=%b exp=%b", k, motor, e);
      end
    end
  endtask

  task automatic test_reverse_low();
    logic [2:0] e;
    int p;
    wait_phase0();
    switch = 3'b001;
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k - 1) % 8;
      if (k <= 2) e = {2'b10, p < 6};
      else if (k <= 6) e = 3'b000;
      else if (k <= 8) e = {2'b01, p < 6};
      else e = {2'b01, p < 4};
      vectors++;
      if (motor !== e || (motor[2] & motor[1])) begin
        errors++;
        $display("FAIL back_fwd k=%0d got=%b exp=%b", k, motor, e);
      end
    end
    switch = 3'b101;
    for (int k = 1; k <= 24; k++) begin
      tick();
      p = (k - 1) % 8;
      if (k <= 2) e = {2'b01, p < 4};
      else if (k <= 6) e = 3'b000;
      else e = {2'b10, p < 4};
      vectors++;
      if (motor !== e || (motor[2] & motor[1])) begin
        errors++;
        $display("FAIL rev_low k=%0d got=%b exp=%b", k, motor, e);
      end
    end
  endtask

  task automatic test_disable();
    logic [2:0] e;
    tick();
    vectors++;
    if (motor !== 3'b101) begin
      errors++;
      $display("FAIL pre_disable got=%b exp=101", motor);
    end
    switch = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = (k <= 2) ? 3'b101 : 3'b000;
      vectors++;
      if (motor !== e) begin
        errors++;
        $display("FAIL disable k=%0d got=%b exp=%b", k, motor, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    switch = 3'b101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if (motor !== 3'b000) begin
        errors++;
        $display("FAIL dead_pre k=%0d got=%b exp=000", k, motor);
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        tick();
        tick();
        vectors++;
        if (motor !== 3'b011) begin
          errors++;
          $display("FAIL pwm_high got=%b exp=011", motor);
        end
      end
      rst = 1'b1;
      switch = 3'b001;
      tick();
      vectors++;
      if (motor !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid r=%0d got=%b exp=000", r, motor);
      end
      rst = 1'b0;
      ncyc = 0;
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (k <= 2) e = 3'b000;
        else if (k <= 8) e = 3'b010;
        else e = {2'b01, ((k - 1) % 8) < 4};
        vectors++;
        if (motor !== e) begin
          errors++;
          $display("FAIL resume r=%0d k=%0d got=%b exp=%b", r, k, motor, e);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    errors = 0;
    ncyc = 0;
    rst = 1'b1;
    switch = 3'b000;
    #1;
    test_reset();
    test_fwd_low();
    test_fwd_high();
    test_reverse();
    test_reverse_low();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pwm_motor_ctrl.md
Name: pwm_motor_ctrl

Overview:
- Drives one DC motor through an H-bridge: one PWM enable line and two direction inputs.
- Three slide switches select run/stop, speed and direction.
- Switches are synchronised into the clock domain. Duty changes are applied on PWM period boundaries.
- A reversal always passes through a dead-time so the bridge never shoots through.

Parameters:
- PERIOD, 8: PWM period in clk cycles (≥2).
- DUTY_LO, 4: high cycles per period at low speed (50%).
- DUTY_HI, 6: high cycles per period at high speed (75%); must satisfy DUTY_LO ≤ DUTY_HI ≤ PERIOD.
- DEAD, 4: dead-time in clk cycles inserted on direction reversal while running (≥1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- switch, input, 3: [0] enable, [1] speed (0 = low, 1 = high), [2] direction (0 = forward, 1 = reverse); asynchronous.
- motor, output, 3: [0] EN/PWM, [1] IN1, [2] IN2; all registered.

Behaviour:
- Reset (rst high at a clk edge):
  - Sync flops, PWM counter cnt, active duty, dead-time counter, latched direction dir_act and motor are all cleared to 0.
  - Reset applied mid-operation aborts any dead-time and PWM period.
- Synchronizer:
  - switch passes through a 2-flop synchronizer; s = switch delayed 2 clocks.
  - en = s[0], spd = s[1], dir = s[2]. All logic below uses s only.
- PWM counter:
  - cnt is free-running, width ceil(log2(PERIOD)), increments every clk.
  - Wraps from PERIOD-1 to 0.
- Active duty:
  - Reloaded only on the clock where cnt == PERIOD-1, so it takes effect from cnt == 0.
  - Value loaded: en ? (spd ? DUTY_HI : DUTY_LO) : 0.
- Disable: when en is low, motor is forced to 000 on the next clk edge, regardless of cnt (immediate stop, coast).
- Direction, en = 0: dir_act follows dir every clock; no dead-time.
- Direction, en = 1 and dir != dir_act (reversal request):
  - Load the dead-time counter with DEAD; motor = 000 while it is nonzero.
  - When the counter reaches 0, dir_act <= dir and normal drive resumes.
  - A further dir toggle during dead-time restarts the count.
  - If en drops during dead-time, the dead-time is cancelled and dir_act <= dir.
- Outputs (registered) when en = 1 and no dead-time:
  - motor[0] = (cnt < duty_act).
  - dir_act = 0: motor[2:1] = 01 (IN1 = 1, IN2 = 0).
  - dir_act = 1: motor[2:1] = 10.
- Invariant: IN1 and IN2 are never both 1.
- Latency:
  - switch edge to s: 2 clocks; s to motor: 1 clock.
  - Enable/speed changes additionally wait for the next period boundary.
- Duty boundaries:
  - DUTY = PERIOD gives EN constantly high while running.
  - Duty 0 gives EN constantly low.

Test Plan:
- rst high 2 clocks, switch = 000 for 20 clocks -> motor = 000 throughout.
- switch = 001 (forward, low) -> after sync plus boundary, motor[2:1] = 01 and motor[0] high 4 of every 8 clocks, repeating.
- switch 001 -> 011 -> motor[0] high 6 of 8 clocks. The change starts exactly at the cnt == 0 cycle; no truncated or extended pulse.
- switch 011 -> 111 (reverse while running) -> motor = 000 for DEAD = 4 clocks, then motor[2:1] = 10 at 75% duty. IN1 and IN2 are never both 1.
- switch 001 -> 101 with en held -> dead-time then reverse at 50%. Then switch = 000 -> motor = 000 within 3 clocks, mid-period.
- Assert rst during dead-time and mid-PWM-high -> motor = 000 on the next clock. After release with switch = 001, normal forward PWM resumes.
